// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed 7-segment driver. BCD digits are double-buffered
// and committed at frame boundaries. Per-digit decode lives in bcd_7seg_lane.
module bcd_7seg_lane #(
    parameter int POS  = 0,
    parameter int NDIG = 3
) (
    input  logic [NDIG-1:0][3:0] d,
    input  logic                 lz,
    output logic [6:0]           seg,
    output logic                 on
);
    logic hz;

    always_comb begin
        hz = 1'b1;
        // this digit blanks only if it and every more-significant digit are zero
        for (int k = POS; k < NDIG; k++) hz &= (d[k] == 4'd0);
        on = !((POS != 0) && lz && hz);
        case (d[POS])
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b1000000;
        endcase
    end
endmodule

module bcd_7seg_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame
);
    localparam int   NDIG = 3;
    localparam int   CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic INV  = (ACTIVE_LOW != 0);

    typedef struct packed {
        logic                 lz;
        logic [NDIG-1:0][3:0] d;
    } dbuf_t;

    logic [CW-1:0]          cnt, cnt_n;
    logic [1:0]             idx, idx_n;
    dbuf_t                  disp, disp_n, pend;
    logic                   pend_flag, tick, commit;
    logic [NDIG-1:0][6:0]   lane_seg;
    logic [NDIG-1:0]        lane_on;
    logic [6:0]             seg_l;
    logic [NDIG-1:0]        an_l;

    assign tick   = (cnt == CW'(REFRESH_DIV - 1));
    assign commit = tick && (idx == 2'd2);

    always_comb begin
        cnt_n  = tick ? '0 : cnt + 1'b1;
        idx_n  = idx;
        if (tick) idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        disp_n = (commit && pend_flag) ? pend : disp;
    end

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_lane
            bcd_7seg_lane #(.POS(g), .NDIG(NDIG)) u_lane (
                .d   (disp_n.d),
                .lz  (disp_n.lz),
                .seg (lane_seg[g]),
                .on  (lane_on[g])
            );
        end
    endgenerate

    // decode next-state values so the registered pins track cnt/idx with no lag
    always_comb begin
        seg_l = '0;
        an_l  = '0;
        if (cnt_n >= CW'(BLANK_CYCLES)) begin
            for (int k = 0; k < NDIG; k++) begin
                if (idx_n == 2'(k)) begin
                    seg_l    = lane_seg[k];
                    an_l[k]  = lane_on[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            disp      <= '0;
            pend      <= '0;
            pend_flag <= 1'b0;
            frame     <= 1'b0;
            seg       <= {7{INV}};
            an        <= {NDIG{INV}};
        end else begin
            cnt   <= cnt_n;
            idx   <= idx_n;
            disp  <= disp_n;
            frame <= commit;
            seg   <= seg_l ^ {7{INV}};
            an    <= an_l ^ {NDIG{INV}};
            if (load) begin
                pend      <= '{lz: blank_lz, d: {bcd2, bcd1, bcd0}};
                pend_flag <= 1'b1;
            end else if (commit) begin
                pend_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: cycle-count reference model of the scan, double
// buffer and decode, driven by directed and random loads.
module tb_bcd_7seg_scan;
    localparam int RD = 4;
    localparam int BC = 1;

    logic       clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [3:0] bcd2 = '0, bcd1 = '0, bcd0 = '0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;

    int compared = 0, mismatched = 0;
    int n = 0;
    logic [3:0] pd[3], dd[3];
    logic       plz = 0, dlz = 0, pf = 0;
    logic [6:0] segtab[16];

    bcd_7seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .blank_lz(blank_lz), .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; pf = 0; plz = 0; dlz = 0;
        for (int k = 0; k < 3; k++) begin pd[k] = 0; dd[k] = 0; end
    endtask

    // one clock: update model with the inputs the DUT saw, then check outputs
    task automatic step();
        int c, i;
        logic cm, en, blank;
        @(posedge clk);
        cm = ((n % RD) == RD - 1) && (((n / RD) % 3) == 2);
        if (cm && pf) begin dd = pd; dlz = plz; end
        if (load) begin
            pd[0] = bcd0; pd[1] = bcd1; pd[2] = bcd2; plz = blank_lz; pf = 1;
        end else if (cm) pf = 0;
        n++;
        #1;
        c = n % RD;
        i = (n / RD) % 3;
        en = (c >= BC);
        blank = dlz && ((i == 2 && dd[2] == 0) || (i == 1 && dd[2] == 0 && dd[1] == 0));
        chk("an", {4'b0, an}, (en && !blank) ? 7'(1 << i) : 7'd0);
        chk("seg", seg, en ? segtab[dd[i]] : 7'd0);
        chk("frame", {6'b0, frame}, {6'b0, cm});
        load = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0,
                           input logic lz);
        bcd2 = a2; bcd1 = a1; bcd0 = a0; blank_lz = lz; load = 1'b1;
    endtask

    // step until the next edge is a commit edge
    task automatic to_commit();
        for (int k = 0; k < 12 && (n % 12) != 11; k++) step();
    endtask

    initial begin
        segtab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                   7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
                   7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                   7'b1000000};
        model_reset();
        #1;
        chk("rst_an", {4'b0, an}, 7'd0);
        chk("rst_seg", seg, 7'd0);
        chk("rst_frame", {6'b0, frame}, 7'd0);
        @(negedge clk) rst = 1'b0;

        // idle scan of zeros
        for (int k = 0; k < 26; k++) step();
        // 255 mid-frame
        do_load(4'd2, 4'd5, 4'd5, 1'b0);
        for (int k = 0; k < 30; k++) step();
        // 007 with and without blanking
        do_load(4'd0, 4'd0, 4'd7, 1'b1);
        for (int k = 0; k < 30; k++) step();
        do_load(4'd0, 4'd0, 4'd7, 1'b0);
        for (int k = 0; k < 30; k++) step();
        // 123 then 456 before commit, 789 on the commit edge
        while ((n % 12) != 3) step();
        do_load(4'd1, 4'd2, 4'd3, 1'b0); step();
        do_load(4'd4, 4'd5, 4'd6, 1'b0); step();
        to_commit();
        do_load(4'd7, 4'd8, 4'd9, 1'b0); step();
        for (int k = 0; k < 26; k++) step();
        // non-decimal tens code
        do_load(4'd3, 4'hC, 4'd1, 1'b0);
        for (int k = 0; k < 26; k++) step();
        // random loads
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0)
                do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            step();
        end
        // mid-slot reset with pending data
        while ((n % 12) != 5) step();
        do_load(4'd9, 4'd8, 4'd7, 1'b0); step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("mrst_an", {4'b0, an}, 7'd0);
        chk("mrst_seg", seg, 7'd0);
        chk("mrst_frame", {6'b0, frame}, 7'd0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 30; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
